// File: rtl/mpmc12_pkg.sv
// ============================================================================
// mpmc12_pkg : shared types and default constants for the mpmc12 address generator
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package mpmc12_pkg;

  typedef enum logic [1:0] {
    AG_IDLE = 2'd0,
    AG_RUN  = 2'd1,
    AG_DONE = 2'd2
  } mpmc12_agen_state_t;

  localparam int          MPMC12_BEAT_BYTES = 32;
  localparam logic [31:0] MPMC12_ADDR_RST   = 32'h3FFF_FFFF;

endpackage

`default_nettype wire

// File: rtl/mpmc12_addr_incr.sv
// ============================================================================
// mpmc12_addr_incr : next-beat address, linear or wrapping in an aligned window
// Optional macro: MPMC_ADDR_WRAP_EN (wrap arithmetic present only when defined)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module mpmc12_addr_incr
  import mpmc12_pkg::*;
#(
  parameter int AW         = 32,
  parameter int BEAT_BYTES = MPMC12_BEAT_BYTES,
  parameter int WRAP_BYTES = 256
) (
  input  logic [AW-1:0] i_addr,
  input  logic          i_wrap_en,
  output logic [AW-1:0] o_addr_next
);

  logic [AW-1:0] w_addr_lin;

  assign w_addr_lin = i_addr + AW'(BEAT_BYTES);

`ifdef MPMC_ADDR_WRAP_EN
  // Bits above the window come from the current address, so carries out of the window are dropped.
  localparam logic [AW-1:0] C_WIN_MASK = AW'(WRAP_BYTES - 1);

  assign o_addr_next = i_wrap_en ? ((i_addr & ~C_WIN_MASK) | (w_addr_lin & C_WIN_MASK))
                                 : w_addr_lin;
`else
  localparam int unused_wrap_bytes = WRAP_BYTES;
  logic          w_unused_wrap_en;

  assign w_unused_wrap_en = i_wrap_en;
  assign o_addr_next      = w_addr_lin;
`endif

endmodule

`default_nettype wire

// File: rtl/mpmc12_addr_gen.sv
// ============================================================================
// mpmc12_addr_gen : burst address generator with run/done FSM, strip count and abort
// Optional macro: MPMC_ADDR_WRAP_EN (critical-word-first wrap within WRAP_BYTES)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module mpmc12_addr_gen
  import mpmc12_pkg::*;
#(
  parameter int          AW         = 32,
  parameter int          SW         = 6,
  parameter int          BEAT_BYTES = MPMC12_BEAT_BYTES,
  parameter logic [31:0] ADDR_RST   = MPMC12_ADDR_RST,
  parameter int          WRAP_BYTES = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic [SW-1:0] i_num_strips,
  input  logic [AW-1:0] i_addr_base,
  input  logic          i_rdy,
  output logic [AW-1:0] o_addr,
  output logic [SW-1:0] o_strip_cnt,
  output logic          o_last,
  output logic          o_busy,
  output logic          o_done
);

  localparam logic [AW-1:0] C_BEAT_MASK = AW'(BEAT_BYTES - 1);

  mpmc12_agen_state_t r_state;
  mpmc12_agen_state_t w_state_nxt;
  logic [AW-1:0]      r_addr;
  logic [SW-1:0]      r_cnt;
  logic [SW-1:0]      r_num;
  logic [AW-1:0]      w_addr_nxt;
  logic               w_wrap_en;
  logic               w_busy;
  logic               w_last;

`ifdef MPMC_ADDR_WRAP_EN
  assign w_wrap_en = 1'b1;
`else
  assign w_wrap_en = 1'b0;
`endif

  mpmc12_addr_incr #(
    .AW         (AW),
    .BEAT_BYTES (BEAT_BYTES),
    .WRAP_BYTES (WRAP_BYTES)
  ) u_incr (
    .i_addr      (r_addr),
    .i_wrap_en   (w_wrap_en),
    .o_addr_next (w_addr_nxt)
  );

  assign w_busy = (r_state == AG_RUN);
  assign w_last = w_busy && (r_cnt == r_num);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= AG_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      AG_IDLE: if (i_start)          w_state_nxt = AG_RUN;
      AG_RUN:  if (i_rdy && w_last)  w_state_nxt = AG_DONE;
      AG_DONE:                       w_state_nxt = AG_IDLE;
      default:                       w_state_nxt = AG_IDLE;
    endcase
    if (i_abort) begin
      w_state_nxt = AG_IDLE;
    end
  end

  // Abort freezes the datapath; on the final beat addr/count stay at their last values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= AW'(ADDR_RST);
      r_cnt  <= '0;
      r_num  <= '0;
    end else if (!i_abort) begin
      if (r_state == AG_IDLE && i_start) begin
        r_addr <= i_addr_base & ~C_BEAT_MASK;
        r_cnt  <= '0;
        r_num  <= i_num_strips;
      end else if (w_busy && i_rdy && !w_last) begin
        r_addr <= w_addr_nxt;
        r_cnt  <= r_cnt + SW'(1);
      end
    end
  end

  assign o_addr      = r_addr;
  assign o_strip_cnt = r_cnt;
  assign o_last      = w_last;
  assign o_busy      = w_busy;
  assign o_done      = (r_state == AG_DONE);

endmodule

`default_nettype wire

// File: tb/tb_mpmc12_addr_gen.sv
// ============================================================================
// tb_mpmc12_addr_gen : randomized self-checking bench for mpmc12_addr_gen
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mpmc12_addr_gen;

  localparam int AW   = 32;
  localparam int SW   = 6;
  localparam int BEAT = 32;
  localparam int WRAP = 128;

  logic          clk;
  logic          rst;
  logic          i_start;
  logic          i_abort;
  logic [SW-1:0] i_num_strips;
  logic [AW-1:0] i_addr_base;
  logic          i_rdy;
  logic [AW-1:0] o_addr;
  logic [SW-1:0] o_strip_cnt;
  logic          o_last;
  logic          o_busy;
  logic          o_done;

  int n_vec = 0;
  int n_err = 0;

  // Values addr/strip_cnt must hold while the generator is idle.
  logic [AW-1:0] m_addr;
  logic [SW-1:0] m_cnt;

  mpmc12_addr_gen #(
    .AW         (AW),
    .SW         (SW),
    .BEAT_BYTES (BEAT),
    .ADDR_RST   (32'h3FFF_FFFF),
    .WRAP_BYTES (WRAP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_num_strips (i_num_strips),
    .i_addr_base  (i_addr_base),
    .i_rdy        (i_rdy),
    .o_addr       (o_addr),
    .o_strip_cnt  (o_strip_cnt),
    .o_last       (o_last),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  // Expected address of beat k of a burst starting at base.
  function automatic logic [31:0] f_exp(input logic [31:0] base, input int k);
    logic [31:0] a;
    logic [31:0] step;
    a    = base & ~32'(BEAT - 1);
    step = 32'(k * BEAT);
`ifdef MPMC_ADDR_WRAP_EN
    return (a & ~32'(WRAP - 1)) | ((a + step) & 32'(WRAP - 1));
`else
    return a + step;
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic [40:0] got;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    got = {o_busy, o_last, o_done, o_strip_cnt, o_addr};
    n_vec++;
    if (got !== {3'b000, 6'd0, 32'h3FFF_FFFF}) begin
      n_err++;
      $display("FAIL reset got=%h exp=%h", got, {3'b000, 6'd0, 32'h3FFF_FFFF});
    end
    m_addr = 32'h3FFF_FFFF;
    m_cnt  = '0;
  endtask

  // mode 0: rdy always 1; mode 1: rdy 1,0,0 repeating; mode 2: random rdy.
  // poke: keep start high with junk base/num during RUN and DONE.
  task automatic test_burst(input logic [31:0] base, input int n, input int mode, input bit poke);
    logic [40:0] got;
    logic [40:0] exp;
    int          k;
    int          cyc;
    int          budget;
    bit          r;
    bit          fin;
    i_addr_base  = base;
    i_num_strips = SW'(n);
    i_start      = 1'b1;
    i_abort      = 1'b0;
    i_rdy        = 1'($urandom % 2);
    tick;
    i_start = poke;
    k       = 0;
    cyc     = 0;
    fin     = 1'b0;
    budget  = 4 * (n + 1) + 16;
    while (!fin && cyc < budget) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 3 == 0);
        default: r = 1'($urandom % 2);
      endcase
      i_rdy = r;
      if (poke) begin
        i_addr_base  = $urandom;
        i_num_strips = SW'($urandom);
      end
      got = {o_busy, o_last, o_done, o_strip_cnt, o_addr};
      exp = {1'b1, (k == n), 1'b0, SW'(k), f_exp(base, k)};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL burst_beat base=%h k=%0d got=%h exp=%h", base, k, got, exp);
      end
      tick;
      cyc++;
      if (r) begin
        if (k == n) fin = 1'b1;
        else        k++;
      end
    end
    if (!fin) begin
      n_vec++;
      n_err++;
      $display("FAIL burst_timeout base=%h got=beat %0d exp=beat %0d", base, k, n);
    end
    i_rdy = 1'($urandom % 2);
    got   = {o_busy, o_last, o_done, o_strip_cnt, o_addr};
    exp   = {3'b001, SW'(n), f_exp(base, n)};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL burst_done base=%h got=%h exp=%h", base, got, exp);
    end
    tick;
    i_start = 1'b0;
    got     = {o_busy, o_last, o_done, o_strip_cnt, o_addr};
    exp     = {3'b000, SW'(n), f_exp(base, n)};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL burst_idle base=%h got=%h exp=%h", base, got, exp);
    end
    m_addr = f_exp(base, n);
    m_cnt  = SW'(n);
  endtask

  task automatic test_abort;
    logic [40:0] got;
    i_addr_base  = 32'h1000_0013;
    i_num_strips = SW'(3);
    i_start      = 1'b1;
    i_rdy        = 1'b1;
    tick;
    i_start = 1'b0;
    got = {o_busy, o_last, o_done, o_strip_cnt, o_addr};
    n_vec++;
    if (got !== {3'b100, 6'd0, 32'h1000_0000}) begin
      n_err++;
      $display("FAIL abort_beat0 got=%h exp=%h", got, {3'b100, 6'd0, 32'h1000_0000});
    end
    tick;
    i_abort = 1'b1;
    tick;
    i_abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      got = {o_busy, o_last, o_done, o_strip_cnt, o_addr};
      n_vec++;
      if (got !== {3'b000, 6'd1, 32'h1000_0020}) begin
        n_err++;
        $display("FAIL abort_hold cyc=%0d got=%h exp=%h", i, got, {3'b000, 6'd1, 32'h1000_0020});
      end
      tick;
    end
    m_addr = 32'h1000_0020;
    m_cnt  = SW'(1);
  endtask

  task automatic test_start_abort_idle;
    logic [40:0] got;
    i_addr_base  = $urandom;
    i_num_strips = SW'($urandom);
    i_start      = 1'b1;
    i_abort      = 1'b1;
    i_rdy        = 1'b1;
    tick;
    i_start = 1'b0;
    i_abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      got = {o_busy, o_last, o_done, o_strip_cnt, o_addr};
      n_vec++;
      if (got !== {3'b000, m_cnt, m_addr}) begin
        n_err++;
        $display("FAIL start_abort_idle cyc=%0d got=%h exp=%h", i, got, {3'b000, m_cnt, m_addr});
      end
      tick;
    end
  endtask

  task automatic test_reset_mid_burst;
    logic [40:0] got;
    i_addr_base  = $urandom;
    i_num_strips = SW'(5);
    i_start      = 1'b1;
    i_rdy        = 1'b1;
    tick;
    i_start = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      got = {o_busy, o_last, o_done, o_strip_cnt, o_addr};
      n_vec++;
      if (got !== {3'b000, 6'd0, 32'h3FFF_FFFF}) begin
        n_err++;
        $display("FAIL reset_mid_burst cyc=%0d got=%h exp=%h", i, got, {3'b000, 6'd0, 32'h3FFF_FFFF});
      end
      tick;
    end
    m_addr = 32'h3FFF_FFFF;
    m_cnt  = '0;
  endtask

  initial begin
    clk          = 1'b0;
    rst          = 1'b1;
    i_start      = 1'b0;
    i_abort      = 1'b0;
    i_rdy        = 1'b0;
    i_num_strips = '0;
    i_addr_base  = '0;
    m_addr       = '0;
    m_cnt        = '0;
    @(negedge clk);

    test_reset;
    test_burst(32'h1000_0013, 3, 0, 1'b0);
    test_burst(32'h1000_0013, 3, 1, 1'b0);
    test_burst($urandom, 0, 0, 1'b0);
    test_burst($urandom, 0, 2, 1'b0);
    test_abort;
    test_start_abort_idle;
    test_burst(32'h1000_0013, 3, 0, 1'b1);
    test_burst(32'h2000_0040, 3, 0, 1'b0);
    test_burst(32'hFFFF_FFE0, 1, 0, 1'b0);
    test_burst($urandom, 63, 2, 1'b0);
    test_reset_mid_burst;
    for (int i = 0; i < 12; i++) begin
      test_burst($urandom, int'($urandom_range(0, 63)), int'($urandom_range(0, 2)), 1'($urandom % 2));
    end
    test_start_abort_idle;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
